lcd_text_driver: RTL

- Downstream consumer of the CPU top's 256-bit debug string: PC, instruction and register value as 32 ASCII characters.
- Drives a 16x2 HD44780-compatible character LCD in 4-bit write-only mode.
- Performs the power-on init sequence, then rewrites both lines whenever a refresh is requested.
- Timing is generated from cycle counters on the single board clock.

---
 rtl/lcd_text_driver_if.sv | 23 ++
 rtl/lcd_text_driver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_driver_if.sv
// lcd_text_driver_if
//   Bundles the host-side request signals and the LCD pin bus of the
//   16x2 HD44780 text driver.
//   slave  : driver side (consumes refresh/strdata, drives busy and the LCD pins)
//   master : host/bench side
//   refresh  host -> drv  single-cycle redraw request
//   strdata  host -> drv  32 ASCII chars, line1 col0 in [255:248]
//   busy     drv -> host  high whenever the driver is not idle
//   LCDRS/LCDRW/LCDE/LCDDAT  drv -> panel, 4-bit write-only bus
interface lcd_text_driver_if;
  logic         refresh;
  logic [255:0] strdata;
  logic         busy;
  logic         LCDRS;
  logic         LCDRW;
  logic         LCDE;
  logic [3:0]   LCDDAT;

  modport slave  (input  refresh, strdata,
                  output busy, LCDRS, LCDRW, LCDE, LCDDAT);
  modport master (output refresh, strdata,
                  input  busy, LCDRS, LCDRW, LCDE, LCDDAT);
endinterface

// File: rtl/lcd_text_driver.sv
// lcd_text_driver
//   Drives a 16x2 HD44780-compatible LCD in 4-bit write-only mode from a
//   256-bit debug string. After reset it runs the power-on init sequence,
//   then rewrites both lines (34 bytes) on each refresh request. Requests
//   arriving while busy are collapsed into one sticky pending redraw.
//   All timing comes from one cycle counter on CLK.
//
//   Ports:
//     CLK  system clock
//     RST  asynchronous reset, active high (restarts from the power wait)
//     bus  lcd_text_driver_if.slave (refresh, strdata, busy, LCD pins)
//
//   Optional build macro: LCD_SKIP_UNCHANGED_EN
//     When defined, an idle refresh whose strdata equals the last written
//     snapshot is dropped. The first frame after reset is always written.
module lcd_text_driver #(
  parameter int unsigned PWR_WAIT  = 750000,
  parameter int unsigned INIT_WAIT = 205000,
  parameter int unsigned E_SETUP   = 2,
  parameter int unsigned E_PULSE   = 12,
  parameter int unsigned NIB_GAP   = 50,
  parameter int unsigned CMD_WAIT  = 2000,
  parameter int unsigned CLR_WAIT  = 82000
) (
  input logic               CLK,
  input logic               RST,
  lcd_text_driver_if.slave  bus
);

  // Counter wide enough for the longest interval.
  localparam int unsigned M0 = (PWR_WAIT > INIT_WAIT) ? PWR_WAIT : INIT_WAIT;
  localparam int unsigned M1 = (M0 > CLR_WAIT) ? M0 : CLR_WAIT;
  localparam int unsigned M2 = (M1 > CMD_WAIT) ? M1 : CMD_WAIT;
  localparam int unsigned M3 = (M2 > NIB_GAP) ? M2 : NIB_GAP;
  localparam int unsigned M4 = (M3 > E_PULSE) ? M3 : E_PULSE;
  localparam int unsigned MX = (M4 > E_SETUP) ? M4 : E_SETUP;
  localparam int unsigned CW = $clog2(MX + 1);

  typedef enum logic [2:0] {ST_PWR, ST_INIT, ST_CFG, ST_IDLE, ST_FRAME} state_e;
  // Phases of one nibble strobe plus the waits that follow it.
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_GAP, PH_WAIT} phase_e;

  state_e         state_q, state_d;
  phase_e         ph_q, ph_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     idx_q, idx_d;     // init nibble / config byte index
  logic           lo_q, lo_d;       // 1 = low nibble of current byte
  logic           cmd_q, cmd_d;     // frame: sending the line address command
  logic [4:0]     chr_q, chr_d;     // frame: character 0..31
  logic           pend_q, pend_d;
  logic [255:0]   snap_q, snap_d;
  logic           rs_q, rs_d;
  logic           e_q, e_d;
  logic [3:0]     dat_q, dat_d;
  logic [CW-1:0]  len_m1;
  logic           done;
  logic           skip;
  logic [7:0]     byte_d;

`ifdef LCD_SKIP_UNCHANGED_EN
  logic written_q, written_d;
  assign skip = written_q && (bus.strdata == snap_q);
`else
  assign skip = 1'b0;
`endif

  // Byte presented for a given position in the config or frame sequence.
  function automatic logic [7:0] byte_sel(input state_e st, input logic [1:0] idx,
                                          input logic cmd, input logic [4:0] chr,
                                          input logic [255:0] snap);
    logic [7:0] b;
    b = 8'h00;
    if (st == ST_CFG) begin
      case (idx)
        2'd0:    b = 8'h28;
        2'd1:    b = 8'h06;
        2'd2:    b = 8'h0C;
        default: b = 8'h01;
      endcase
    end else if (st == ST_FRAME) begin
      if (cmd) b = chr[4] ? 8'hC0 : 8'h80;
      else     b = snap[{~chr, 3'b000} +: 8];  // char 0 lives in the top byte
    end
    return b;
  endfunction

  // Length (minus one) of the interval currently being timed.
  always_comb begin
    len_m1 = CW'(CMD_WAIT - 1);
    if (state_q == ST_PWR) begin
      len_m1 = CW'(PWR_WAIT - 1);
    end else begin
      case (ph_q)
        PH_SETUP: len_m1 = CW'(E_SETUP - 1);
        PH_PULSE: len_m1 = CW'(E_PULSE - 1);
        PH_GAP:   len_m1 = CW'(NIB_GAP - 1);
        default: begin
          if (state_q == ST_INIT)
            len_m1 = (idx_q == 2'd3) ? CW'(CMD_WAIT - 1) : CW'(INIT_WAIT - 1);
          else if (state_q == ST_CFG && idx_q == 2'd3)
            len_m1 = CW'(CLR_WAIT - 1);
          else
            len_m1 = CW'(CMD_WAIT - 1);
        end
      endcase
    end
  end

  assign done = (cnt_q == len_m1);

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    lo_d    = lo_q;
    cmd_d   = cmd_q;
    chr_d   = chr_q;
    pend_d  = pend_q;
    snap_d  = snap_q;
`ifdef LCD_SKIP_UNCHANGED_EN
    written_d = written_q;
`endif

    if (state_q != ST_IDLE && bus.refresh) pend_d = 1'b1;

    case (state_q)
      ST_PWR: begin
        if (done) begin
          state_d = ST_INIT;
          ph_d    = PH_SETUP;
          idx_d   = 2'd0;
          lo_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.refresh || pend_q) begin
          pend_d = 1'b0;
          if (!skip) begin
            snap_d  = bus.strdata;
            state_d = ST_FRAME;
            ph_d    = PH_SETUP;
            cmd_d   = 1'b1;
            chr_d   = 5'd0;
            lo_d    = 1'b0;
`ifdef LCD_SKIP_UNCHANGED_EN
            written_d = 1'b1;
`endif
          end
        end
      end
      default: begin
        if (done) begin
          cnt_d = '0;
          case (ph_q)
            PH_SETUP: ph_d = PH_PULSE;
            // Init nibbles are single strobes; bytes go through the gap.
            PH_PULSE: ph_d = (state_q != ST_INIT && !lo_q) ? PH_GAP : PH_WAIT;
            PH_GAP: begin
              ph_d = PH_SETUP;
              lo_d = 1'b1;
            end
            default: begin
              ph_d = PH_SETUP;
              lo_d = 1'b0;
              case (state_q)
                ST_INIT: begin
                  idx_d = idx_q + 2'd1;
                  if (idx_q == 2'd3) state_d = ST_CFG;
                end
                ST_CFG: begin
                  idx_d = idx_q + 2'd1;
                  if (idx_q == 2'd3) state_d = ST_IDLE;
                end
                default: begin
                  if (cmd_q) begin
                    cmd_d = 1'b0;
                  end else if (chr_q == 5'd31) begin
                    state_d = ST_IDLE;
                  end else begin
                    chr_d = chr_q + 5'd1;
                    if (chr_q == 5'd15) cmd_d = 1'b1;  // 0xC0 before line 2
                  end
                end
              endcase
            end
          endcase
        end
      end
    endcase
  end

  // Pin values are registered from the next state so they change only at
  // the start of a setup phase and hold through pulse, gap and wait.
  always_comb begin
    byte_d = byte_sel(state_d, idx_d, cmd_d, chr_d, snap_d);
    rs_d   = 1'b0;
    dat_d  = 4'h0;
    e_d    = 1'b0;
    case (state_d)
      ST_INIT: dat_d = (idx_d == 2'd3) ? 4'h2 : 4'h3;
      ST_CFG:  dat_d = lo_d ? byte_d[3:0] : byte_d[7:4];
      ST_FRAME: begin
        dat_d = lo_d ? byte_d[3:0] : byte_d[7:4];
        rs_d  = !cmd_d;
      end
      default: dat_d = 4'h0;
    endcase
    if (state_d == ST_INIT || state_d == ST_CFG || state_d == ST_FRAME)
      e_d = (ph_d == PH_PULSE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_PWR;
      ph_q    <= PH_SETUP;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      lo_q    <= 1'b0;
      cmd_q   <= 1'b0;
      chr_q   <= 5'd0;
      pend_q  <= 1'b0;
      snap_q  <= '0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      dat_q   <= 4'h0;
`ifdef LCD_SKIP_UNCHANGED_EN
      written_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      cmd_q   <= cmd_d;
      chr_q   <= chr_d;
      pend_q  <= pend_d;
      snap_q  <= snap_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      dat_q   <= dat_d;
`ifdef LCD_SKIP_UNCHANGED_EN
      written_q <= written_d;
`endif
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.LCDRS  = rs_q;
  assign bus.LCDRW  = 1'b0;
  assign bus.LCDE   = e_q;
  assign bus.LCDDAT = dat_q;

endmodule
